// File: rtl/mgt01_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mgt01_div_unit_pkg
// Brief   : Shared types and constants for the RV32M divide/remainder unit.
// Revision: 1.0 - initial release
// ============================================================================
package mgt01_div_unit_pkg;

    localparam int XLEN   = 32;
    localparam int ITER_W = $clog2(XLEN);

    typedef enum logic [0:0] {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    // Values mirror the RV32M funct3 field so decode can pass it straight through.
    typedef enum logic [2:0] {
        DIV_  = 3'b100,
        DIVU_ = 3'b101,
        REM_  = 3'b110,
        REMU_ = 3'b111
    } div_ops_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIVIDE   = 2'd1,
        FINALIZE = 2'd2
    } div_state_e;

    function automatic logic is_signed_op(input div_ops_e op);
        return (op == DIV_) || (op == REM_);
    endfunction

    function automatic logic is_rem_op(input div_ops_e op);
        return (op == REM_) || (op == REMU_);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mgt01_div_step.sv
`default_nettype none
// ============================================================================
// Module  : mgt01_div_step
// Brief   : One combinational radix-2 restoring division step on magnitudes.
// Revision: 1.0 - initial release
// ============================================================================
module mgt01_div_step
    import mgt01_div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] w_rem_shift;
    logic [XLEN:0] w_trial;

    // Remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
    assign w_rem_shift = {rem_i, quo_i[XLEN-1]};
    assign w_trial     = w_rem_shift - {1'b0, divisor_i};

    always_comb begin
        rem_o = w_rem_shift[XLEN-1:0];
        quo_o = {quo_i[XLEN-2:0], 1'b0};
        if (!w_trial[XLEN]) begin
            rem_o = w_trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mgt01_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mgt01_div_unit
// Brief   : Iterative RV32M DIV/DIVU/REM/REMU unit, one operation in flight.
// Revision: 1.0 - initial release
// ============================================================================
module mgt01_div_unit
    import mgt01_div_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  div_ops_e        operation_i,
    output logic [XLEN-1:0] result_o,
    output fu_state_e       fu_state_o,
    output logic            valid_o
);

    localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        r_state;
    logic [ITER_W-1:0] r_counter;
    div_ops_e          r_op;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_bypass;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_divisor;

    logic              w_signed;
    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_overflow;
    logic [XLEN-1:0]   w_step_rem;
    logic [XLEN-1:0]   w_step_quo;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    assign w_signed   = is_signed_op(operation_i);
    assign w_sign_a   = w_signed & dividend_i[XLEN-1];
    assign w_sign_b   = w_signed & divisor_i[XLEN-1];
    assign w_overflow = w_signed && (dividend_i == C_MIN_NEG) && (divisor_i == '1);

    // Quotient sign follows the operand signs; remainder takes the dividend's sign.
    assign w_quo_fix  = (!r_bypass && (r_sign_a ^ r_sign_b)) ? -r_quo : r_quo;
    assign w_rem_fix  = (!r_bypass && r_sign_a) ? -r_rem : r_rem;

    assign fu_state_o = (r_state == IDLE) ? FREE : BUSY;

    mgt01_div_step u_step (
        .rem_i     (r_rem),
        .quo_i     (r_quo),
        .divisor_i (r_divisor),
        .rem_o     (w_step_rem),
        .quo_o     (w_step_quo)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_op      <= DIV_;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_bypass  <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            result_o  <= '0;
            valid_o   <= 1'b0;
        end else if (clk_en_i) begin
            valid_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_op      <= operation_i;
                        r_sign_a  <= w_sign_a;
                        r_sign_b  <= w_sign_b;
                        r_divisor <= w_sign_b ? -divisor_i : divisor_i;
                        r_counter <= ITER_W'(XLEN-1);
                        if (divisor_i == '0) begin
                            r_quo    <= '1;
                            r_rem    <= dividend_i;
                            r_bypass <= 1'b1;
                            r_state  <= FINALIZE;
                        end else if (w_overflow) begin
                            r_quo    <= C_MIN_NEG;
                            r_rem    <= '0;
                            r_bypass <= 1'b1;
                            r_state  <= FINALIZE;
                        end else begin
                            r_quo    <= w_sign_a ? -dividend_i : dividend_i;
                            r_rem    <= '0;
                            r_bypass <= 1'b0;
                            r_state  <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    r_quo <= w_step_quo;
                    r_rem <= w_step_rem;
                    if (r_counter == '0) begin
                        r_state <= FINALIZE;
                    end else begin
                        r_counter <= r_counter - ITER_W'(1);
                    end
                end
                FINALIZE: begin
                    result_o <= is_rem_op(r_op) ? w_rem_fix : w_quo_fix;
                    valid_o  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mgt01_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mgt01_div_unit
// Brief   : Self-checking bench: arithmetic reference model plus directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mgt01_div_unit;
    import mgt01_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clk_en = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    div_ops_e    op = DIV_;
    logic [31:0] result_o;
    fu_state_e   fu_state_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;

    mgt01_div_unit dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .clk_en_i    (clk_en),
        .valid_i     (valid_i),
        .dividend_i  (a),
        .divisor_i   (b),
        .operation_i (op),
        .result_o    (result_o),
        .fu_state_o  (fu_state_o),
        .valid_o     (valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic is_bypass(input div_ops_e o, input logic [31:0] x, input logic [31:0] y);
        return (y == 0) ||
               (((o == DIV_) || (o == REM_)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF));
    endfunction

    // RISC-V results from plain integer arithmetic (SV division truncates toward zero).
    function automatic logic [31:0] model(input div_ops_e o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0)
            return ((o == DIV_) || (o == DIVU_)) ? 32'hFFFF_FFFF : x;
        if (is_bypass(o, x, y))
            return (o == DIV_) ? x : 32'h0;
        case (o)
            DIV_:    return $signed(x) / $signed(y);
            REM_:    return $signed(x) % $signed(y);
            DIVU_:   return x / y;
            default: return x % y;
        endcase
    endfunction

    // Spec-level timing: result appears a fixed number of enabled cycles after acceptance.
    logic        m_busy  = 1'b0;
    int          m_left  = 0;
    logic [31:0] m_pend  = '0;
    logic [31:0] m_res   = '0;
    logic        m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_left  <= 0;
            m_res   <= '0;
            m_valid <= 1'b0;
        end else if (clk_en) begin
            m_valid <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_res   <= m_pend;
                end
                m_left <= m_left - 1;
            end else if (valid_i) begin
                m_pend <= model(op, a, b);
                m_left <= is_bypass(op, a, b) ? 1 : 33;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid", {31'b0, valid_o}, {31'b0, m_valid});
        chk("cyc_state", {31'b0, fu_state_o}, {31'b0, m_busy});
        chk("cyc_result", result_o, m_res);
    end

    // Called at a negedge; returns at the negedge where valid_o is seen high.
    task automatic do_op(input div_ops_e o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] lit, input int lat, input bit hold,
                         input bit stall, input string nm);
        int n = 0;
        op = o; a = x; b = y; valid_i = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (valid_o) break;
            if (n == 1) begin
                a = $urandom;
                b = $urandom;
                if (!hold) valid_i = 1'b0;
            end
            if (stall && n == 5)  clk_en = 1'b0;
            if (stall && n == 15) clk_en = 1'b1;
        end
        valid_i = 1'b0;
        chk({nm, "_done"}, {31'b0, valid_o}, 32'd1);
        chk(nm, result_o, lit);
        chk({nm, "_lat"}, n - 1, lat);
    endtask

    initial begin
        int seen;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", result_o, 32'h0);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_state", {31'b0, fu_state_o}, {31'b0, FREE});
        #2 rst_n = 1'b1;
        @(negedge clk);

        do_op(DIV_,  32'd100,      32'd7,        32'd14,       33, 0, 0, "div_100_7");
        do_op(REM_,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33, 0, 0, "rem_m100_7");
        do_op(DIV_,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33, 0, 0, "div_m100_7");
        do_op(DIVU_, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33, 0, 0, "divu_max_2");
        do_op(REMU_, 32'hFFFFFFFF, 32'd2,        32'd1,        33, 0, 0, "remu_max_2");
        repeat (3) @(negedge clk);
        do_op(DIV_,  32'd5,        32'd0,        32'hFFFFFFFF, 1,  0, 0, "div_by0");
        do_op(REM_,  32'd5,        32'd0,        32'd5,        1,  0, 0, "rem_by0");
        do_op(REMU_, 32'h80000000, 32'd0,        32'h80000000, 1,  0, 0, "remu_by0");
        do_op(DIV_,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, 0, "div_ovf");
        do_op(REM_,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0, 0, "rem_ovf");
        do_op(DIV_,  32'd1000,     32'hFFFFFFFD, 32'hFFFFFEB3, 43, 0, 1, "div_stall");
        do_op(DIVU_, 32'd12345,    32'd10,       32'd1234,     33, 1, 0, "divu_hold");
        do_op(REM_,  32'd7,        32'hFFFFFF9C, 32'd7,        33, 0, 0, "rem_7_m100");
        do_op(REM_,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33, 0, 0, "rem_m7_m2");

        // Abort an operation part-way with reset.
        op = DIV_; a = 32'd1000; b = 32'd7; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", result_o, 32'h0);
        chk("abort_valid", {31'b0, valid_o}, 32'h0);
        chk("abort_state", {31'b0, fu_state_o}, {31'b0, FREE});
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        chk("abort_no_valid", seen, 0);

        do_op(DIV_,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33, 0, 0, "div_m7_m2");
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mgt01_div_unit.md
Name: mgt01_div_unit

Overview:
- Iterative RV32M divide/remainder functional unit; the inverse-operation counterpart of the multiplication unit.
- Sits in the integer execute stage beside the multiplier and reports status through the same fu_state_e / valid_o scheme.
- Implements a radix-2 restoring divider on magnitudes with sign fix-up, plus a short-circuit path for RISC-V special cases.
- Non-pipelined: one operation in flight.

Parameters:
- XLEN, 32 (from shared package): operand/result width.
- ITER_W, $clog2(XLEN): iteration counter width.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- clk_en_i  in  1  clock enable; low freezes all state
- valid_i  in  1  start request; sampled only in IDLE
- dividend_i  in  XLEN  signed dividend (rs1)
- divisor_i  in  XLEN  signed divisor (rs2)
- operation_i  in  div_ops_e  DIV_, DIVU_, REM_, REMU_
- result_o  out  XLEN  quotient or remainder, registered
- fu_state_o  out  fu_state_e  FREE in IDLE, BUSY otherwise
- valid_o  out  1  one-cycle pulse, result_o valid

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counter=0
  - result_o=0, valid_o=0, fu_state_o=FREE
  - internal quotient/remainder/operand registers all 0
- States: IDLE, DIVIDE, FINALIZE. All transitions are gated by clk_en_i=1. With clk_en_i=0 every register, including valid_o, holds its value.
- IDLE, valid_i=1 (acceptance edge E0):
  - Latch operation_i.
  - Compute signs: signed ops use bit XLEN-1; unsigned ops force sign=0.
  - Latch |dividend| and |divisor|. Clear remainder. Counter=XLEN-1.
  - Special case divisor==0: preset quotient=all ones, remainder=dividend_i; go to FINALIZE with bypass flag.
  - Special case signed overflow (DIV_/REM_, dividend=0x80000000, divisor=all ones): preset quotient=0x80000000, remainder=0; go to FINALIZE with bypass.
  - Otherwise go to DIVIDE.
- DIVIDE: one restoring step per enabled cycle.
  - Compute {rem,quo} shifted left 1 bit.
  - Trial = rem - divisor (XLEN+1 bits).
  - If the trial is non-negative: rem=trial, quo[0]=1. Else quo[0]=0.
  - When counter==0, go to FINALIZE; else decrement counter.
  - Exactly XLEN iterations (edges E1..E32).
- FINALIZE (1 cycle):
  - Unless bypass: negate quotient if sign(dividend) XOR sign(divisor); negate remainder if sign(dividend).
  - Register result_o: quotient for DIV_/DIVU_, remainder for REM_/REMU_.
  - valid_o<=1; go to IDLE.
- Latency, acceptance edge to valid_o high:
  - Normal: 33 enabled cycles (E33).
  - Bypass: 1 enabled cycle (E1).
- valid_o: high for exactly one enabled cycle, cleared on the next enabled edge. result_o holds until the next FINALIZE.
- valid_i while BUSY: ignored, no queueing. valid_i in the same cycle valid_o is high: accepted (state is IDLE), back-to-back.
- Inputs need only be stable at E0; later changes have no effect.
- Reset mid-operation: immediate abort to reset values; no valid_o.

Decomposition:
- Shared package (Modules_pkg):
  - div_ops_e (DIV_, DIVU_, REM_, REMU_)
  - existing fu_state_e and XLEN
  - div_state_e (IDLE, DIVIDE, FINALIZE)
- Instruction package: reuse funct3 encodings for div_ops_e values.
- One natural sub-module: mgt01_div_step, combinational single restoring step (rem, quo, divisor in; rem, quo out). The top holds the FSM, counter and sign logic.

Test Plan:
- DIV_ 100 / 7 -> result_o=14; valid_o pulses exactly 33 cycles after acceptance; fu_state_o BUSY for cycles E0..E32.
- REM_ -100 (0xFFFFFF9C) / 7 -> 0xFFFFFFFE (-2); DIV_ same operands -> 0xFFFFFFF2 (-14).
- DIVU_ 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU_ same -> 1.
- Divide-by-zero:
  - DIV_ 5 / 0 -> 0xFFFFFFFF; REM_ 5 / 0 -> 5; REMU_ 0x80000000 / 0 -> 0x80000000.
  - All with valid_o one cycle after acceptance.
- Overflow: DIV_ 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM_ same -> 0; latency 1.
- Robustness:
  - clk_en_i low for 10 cycles mid-DIVIDE -> result unchanged, latency +10.
  - rst_n_i pulse at E15 -> outputs 0, FREE, no valid_o.
  - valid_i held high while BUSY -> only the first operation executes.
  - New request in the valid_o cycle -> second result 33 cycles later.
